// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the fetch FSM state encoding.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] HALT_WORD_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  // Fetch targets are always word aligned; the low two bits of a target are dropped.
  function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-side bus: instruction memory port, redirect input and the decode-facing queue head.
interface inst_fetch_queue_if
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] IMEM_ADDR;
  logic [XLEN-1:0] IMEM_INST;
  logic            REDIRECT;
  logic [XLEN-1:0] REDIRECT_PC;
  logic            OUT_VALID;
  logic            OUT_READY;
  logic [XLEN-1:0] OUT_PC;
  logic [XLEN-1:0] OUT_INST;
  logic            HALTED;
  logic [CW-1:0]   COUNT;

  modport master (
    output IMEM_ADDR, OUT_VALID, OUT_PC, OUT_INST, HALTED, COUNT,
    input  IMEM_INST, REDIRECT, REDIRECT_PC, OUT_READY
  );

  modport slave (
    input  IMEM_ADDR, OUT_VALID, OUT_PC, OUT_INST, HALTED, COUNT,
    output IMEM_INST, REDIRECT, REDIRECT_PC, OUT_READY
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small circular queue of {pc, instruction} pairs with push, pop, flush and occupancy count.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [XLEN-1:0]            push_pc_i,
  input  logic [XLEN-1:0]            push_inst_i,
  output logic [XLEN-1:0]            head_pc_o,
  output logic [XLEN-1:0]            head_inst_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  mem_pc_q   [DEPTH];
  logic [XLEN-1:0]  mem_inst_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointers wrap naturally; flush overrides any push or pop.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + PTR_W'(1);
      if (pop_i)  rd_d = rd_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]   <= '0;
        mem_inst_q[i] <= '0;
      end
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      if (push_i && !flush_i) begin
        mem_pc_q[wr_q]   <= push_pc_i;
        mem_inst_q[wr_q] <= push_inst_i;
      end
    end
  end

  assign head_pc_o   = mem_pc_q[rd_q];
  assign head_inst_o = mem_inst_q[rd_q];
  assign count_o     = count_q;
  assign full_o      = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit: PC register, RUN/HALT fetch FSM and redirect handling in front of a fetch queue.
module inst_fetch_queue
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              DEPTH     = 2,
  parameter logic [XLEN-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input logic                 CLK,
  input logic                 RST,
  inst_fetch_queue_if.master  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_q;
  fetch_state_e    state_q;
  logic            halted_q;

  logic [CW-1:0]   fifoCount;
  logic            fifoFull;
  logic [XLEN-1:0] headPc;
  logic [XLEN-1:0] headInst;
  logic            outValid;
  logic            popEn;
  logic            pushEn;
  logic            isHaltWord;

  assign outValid   = (fifoCount != '0);
  assign popEn      = outValid && bus.OUT_READY;
  assign isHaltWord = (bus.IMEM_INST == HALT_WORD);
  assign pushEn     = (state_q == RUN) && !bus.REDIRECT && !isHaltWord && (!fifoFull || popEn);

  // Redirect beats halt and push; a halt word is never queued and freezes the PC on itself.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q     <= RESET_PC;
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else if (bus.REDIRECT) begin
      pc_q     <= alignPc(bus.REDIRECT_PC);
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (isHaltWord) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else if (pushEn) begin
            pc_q <= pc_q + 32'd4;
          end
        end
        HALT: begin
          state_q  <= HALT;
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk         (CLK),
    .rst         (RST),
    .push_i      (pushEn),
    .pop_i       (popEn),
    .flush_i     (bus.REDIRECT),
    .push_pc_i   (pc_q),
    .push_inst_i (bus.IMEM_INST),
    .head_pc_o   (headPc),
    .head_inst_o (headInst),
    .count_o     (fifoCount),
    .full_o      (fifoFull)
  );

  assign bus.IMEM_ADDR = pc_q;
  assign bus.OUT_VALID = outValid;
  assign bus.OUT_PC    = headPc;
  assign bus.OUT_INST  = headInst;
  assign bus.HALTED    = halted_q;
  assign bus.COUNT     = fifoCount;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: vector table, pop scoreboard and hand-written corner sequences.
module tb_inst_fetch_queue;

  typedef struct {
    logic        ready;
    logic        redirect;
    logic [31:0] rpc;
    logic [31:0] expCount;
    logic [31:0] expAddr;
    logic        expValid;
    logic        chkPc;
    logic [31:0] expPc;
    logic        expHalted;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } sb_t;

  logic CLK;
  logic RST;
  int   total;
  int   bad;
  int   memModeA;
  logic sbEnable;
  logic done;
  sb_t  sbq[$];
  sb_t  sbItem;
  vec_t vecs[12];

  inst_fetch_queue_if #(.DEPTH(2)) ifA ();
  inst_fetch_queue_if #(.DEPTH(2)) ifB ();

  inst_fetch_queue #(
    .RESET_PC  (32'h0000_0000),
    .DEPTH     (2),
    .HALT_WORD (32'h0000_0000)
  ) dutA (
    .CLK (CLK),
    .RST (RST),
    .bus (ifA)
  );

  inst_fetch_queue #(
    .RESET_PC  (32'hFFFF_FFF8),
    .DEPTH     (2),
    .HALT_WORD (32'h0000_0000)
  ) dutB (
    .CLK (CLK),
    .RST (RST),
    .bus (ifB)
  );

  // Mode 0 holds the short program ending in a halt word; mode 1 returns a nonzero word for every address.
  function automatic logic [31:0] memWord(input logic [31:0] addr, input int mode);
    if (mode == 0) begin
      case (addr)
        32'h0:   return 32'h0050_0093;
        32'h4:   return 32'h00A0_0113;
        32'h8:   return 32'h0020_81B3;
        default: return 32'h0000_0000;
      endcase
    end
    return addr ^ 32'h1357_9BDF;
  endfunction

  assign ifA.IMEM_INST = memWord(ifA.IMEM_ADDR, memModeA);
  assign ifB.IMEM_INST = memWord(ifB.IMEM_ADDR, 1);

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    ifA.OUT_READY   = v.ready;
    ifA.REDIRECT    = v.redirect;
    ifA.REDIRECT_PC = v.rpc;
  endtask

  task automatic sbPush(input logic [31:0] pc, input int mode);
    sb_t e;
    e.pc   = pc;
    e.inst = memWord(pc, mode);
    sbq.push_back(e);
  endtask

  task automatic doReset();
    RST             = 1'b1;
    ifA.OUT_READY   = 1'b0;
    ifA.REDIRECT    = 1'b0;
    ifA.REDIRECT_PC = 32'h0;
    ifB.OUT_READY   = 1'b0;
    ifB.REDIRECT    = 1'b0;
    ifB.REDIRECT_PC = 32'h0;
    sbq.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic waitHaltDrained(input string name);
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      #1;
      if (ifA.HALTED && !ifA.OUT_VALID) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput(name, 32'(done), 32'd1);
  endtask

  // Every accepted head entry must match the next expected {pc, inst} in order.
  always @(negedge CLK) begin
    if (sbEnable && !RST && ifA.OUT_VALID && ifA.OUT_READY) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL sb_extra_pop got pc=%h want none", ifA.OUT_PC);
      end else begin
        sbItem = sbq.pop_front();
        checkOutput("sb_pc", ifA.OUT_PC, sbItem.pc);
        checkOutput("sb_inst", ifA.OUT_INST, sbItem.inst);
      end
    end
  end

  initial begin
    total    = 0;
    bad      = 0;
    sbEnable = 1'b0;
    memModeA = 0;

    // ready, redirect, rpc, count, addr, valid, chkPc, pc, halted
    vecs[0]  = '{1'b0, 1'b0, 32'h0,   32'd1, 32'h004, 1'b1, 1'b1, 32'h000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   32'd2, 32'h008, 1'b1, 1'b1, 32'h000, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   32'd2, 32'h008, 1'b1, 1'b1, 32'h000, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   32'd2, 32'h008, 1'b1, 1'b1, 32'h000, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,   32'd2, 32'h008, 1'b1, 1'b1, 32'h000, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,   32'd2, 32'h00C, 1'b1, 1'b1, 32'h004, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,   32'd2, 32'h010, 1'b1, 1'b1, 32'h008, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   32'd2, 32'h010, 1'b1, 1'b1, 32'h008, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 32'h103, 32'd0, 32'h100, 1'b0, 1'b0, 32'h000, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,   32'd1, 32'h104, 1'b1, 1'b1, 32'h100, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h0,   32'd1, 32'h108, 1'b1, 1'b1, 32'h104, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,   32'd2, 32'h10C, 1'b1, 1'b1, 32'h104, 1'b0};

    // Reset state before the first edge
    doReset();
    checkOutput("rst_count", 32'(ifA.COUNT), 32'd0);
    checkOutput("rst_valid", 32'(ifA.OUT_VALID), 32'd0);
    checkOutput("rst_addr", ifA.IMEM_ADDR, 32'h0);
    checkOutput("rst_halted", 32'(ifA.HALTED), 32'd0);
    checkOutput("rst_out_pc", ifA.OUT_PC, 32'h0);
    checkOutput("rst_out_inst", ifA.OUT_INST, 32'h0);

    // Program stream with decode always ready, ending at the halt word
    memModeA = 0;
    sbEnable = 1'b1;
    sbPush(32'h0, 0);
    sbPush(32'h4, 0);
    sbPush(32'h8, 0);
    ifA.OUT_READY = 1'b1;
    waitHaltDrained("stream_halt_reached");
    checkOutput("stream_halted", 32'(ifA.HALTED), 32'd1);
    checkOutput("stream_valid", 32'(ifA.OUT_VALID), 32'd0);
    checkOutput("stream_addr", ifA.IMEM_ADDR, 32'hC);
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("stream_sb_left", 32'(sbq.size()), 32'd0);
    checkOutput("stream_addr_hold", ifA.IMEM_ADDR, 32'hC);

    // Redirect out of HALT
    sbPush(32'h4, 0);
    sbPush(32'h8, 0);
    ifA.REDIRECT    = 1'b1;
    ifA.REDIRECT_PC = 32'h4;
    @(posedge CLK);
    #1;
    ifA.REDIRECT = 1'b0;
    checkOutput("rdh_halted", 32'(ifA.HALTED), 32'd0);
    checkOutput("rdh_addr", ifA.IMEM_ADDR, 32'h4);
    @(posedge CLK);
    #1;
    checkOutput("rdh_valid", 32'(ifA.OUT_VALID), 32'd1);
    checkOutput("rdh_out_pc", ifA.OUT_PC, 32'h4);
    waitHaltDrained("rdh_halt_again");
    checkOutput("rdh_sb_left", 32'(sbq.size()), 32'd0);

    // Table: backpressure, drain without gaps, redirect beating a same-cycle pop
    doReset();
    memModeA = 1;
    sbPush(32'h000, 1);
    sbPush(32'h004, 1);
    sbPush(32'h008, 1);
    sbPush(32'h100, 1);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      @(posedge CLK);
      #1;
      checkOutput($sformatf("vec%0d_count", i), 32'(ifA.COUNT), vecs[i].expCount);
      checkOutput($sformatf("vec%0d_addr", i), ifA.IMEM_ADDR, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d_valid", i), 32'(ifA.OUT_VALID), 32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d_halted", i), 32'(ifA.HALTED), 32'(vecs[i].expHalted));
      if (vecs[i].chkPc) begin
        checkOutput($sformatf("vec%0d_out_pc", i), ifA.OUT_PC, vecs[i].expPc);
      end
    end
    ifA.OUT_READY = 1'b0;
    ifA.REDIRECT  = 1'b0;
    #1;
    checkOutput("vec_sb_left", 32'(sbq.size()), 32'd0);

    // Redirect with the queue full at PC 8 to a misaligned target
    doReset();
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rdf_count_full", 32'(ifA.COUNT), 32'd2);
    checkOutput("rdf_addr_full", ifA.IMEM_ADDR, 32'h8);
    ifA.REDIRECT    = 1'b1;
    ifA.REDIRECT_PC = 32'h42;
    @(posedge CLK);
    #1;
    ifA.REDIRECT = 1'b0;
    checkOutput("rdf_count", 32'(ifA.COUNT), 32'd0);
    checkOutput("rdf_addr", ifA.IMEM_ADDR, 32'h40);
    @(posedge CLK);
    #1;
    checkOutput("rdf_valid", 32'(ifA.OUT_VALID), 32'd1);
    checkOutput("rdf_out_pc", ifA.OUT_PC, 32'h40);
    checkOutput("rdf_out_inst", ifA.OUT_INST, 32'h40 ^ 32'h1357_9BDF);

    // PC wrap-around on the second instance
    doReset();
    ifB.OUT_READY = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("wrap_pc0", ifB.OUT_PC, 32'hFFFF_FFF8);
    checkOutput("wrap_inst0", ifB.OUT_INST, 32'hFFFF_FFF8 ^ 32'h1357_9BDF);
    @(posedge CLK);
    #1;
    checkOutput("wrap_pc1", ifB.OUT_PC, 32'hFFFF_FFFC);
    checkOutput("wrap_addr1", ifB.IMEM_ADDR, 32'h0);
    @(posedge CLK);
    #1;
    checkOutput("wrap_pc2", ifB.OUT_PC, 32'h0);
    checkOutput("wrap_valid2", 32'(ifB.OUT_VALID), 32'd1);

    // Asynchronous reset between edges
    doReset();
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("arst_count_before", 32'(ifA.COUNT), 32'd2);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("arst_valid", 32'(ifA.OUT_VALID), 32'd0);
    checkOutput("arst_addr", ifA.IMEM_ADDR, 32'h0);
    checkOutput("arst_count", 32'(ifA.COUNT), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    checkOutput("arst_first_push", 32'(ifA.COUNT), 32'd1);
    checkOutput("arst_first_addr", ifA.IMEM_ADDR, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound the run in case a wait never resolves.
  initial begin
    #200000;
    bad++;
    $display("[TB] FAIL timeout got=running want=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameter RESET_PC, 32'h00000000, PC value loaded on reset.
REQ-002 Parameter DEPTH, 2, fetch queue entries; legal values 2 or 4.
REQ-003 Parameter HALT_WORD, 32'h00000000, fetched word that stops fetch.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high. Ports are listed below.
REQ-005 CLK  input  1  rising-edge clock.
REQ-006 RST  input  1  asynchronous active-high reset.
REQ-007 IMEM_ADDR  output  32  instruction memory address; combinational copy of PC.
REQ-008 IMEM_INST  input  32  instruction word returned combinationally for IMEM_ADDR.
REQ-009 REDIRECT  input  1  branch/jump taken; flush and restart fetch.
REQ-010 REDIRECT_PC  input  32  new fetch target.
REQ-011 OUT_VALID  output  1  head entry valid toward decode.
REQ-012 OUT_READY  input  1  decode accepts the head entry this cycle.
REQ-013 OUT_PC  output  32  PC of the head entry.
REQ-014 OUT_INST  output  32  instruction of the head entry.
REQ-015 HALTED  output  1  fetch FSM is in HALT.
REQ-016 COUNT  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-017 The FSM SHALL have exactly two states: RUN and HALT.
REQ-018 pop SHALL equal OUT_VALID && OUT_READY.
REQ-019 In RUN with REDIRECT=0, a push SHALL occur when the queue is not full, or when it is full and pop is 1.
- Push stores {PC, IMEM_INST}.
- Push sets PC <= PC+4.
REQ-020 PC arithmetic SHALL be modulo 2^32: 32'hFFFFFFFC+4 = 0.
REQ-021 If IMEM_INST == HALT_WORD in RUN, the word SHALL NOT be pushed.
- The FSM goes to HALT and PC holds.
REQ-022 In HALT, no push SHALL occur; queued entries keep draining via pop.
REQ-023 REDIRECT=1 SHALL have priority over push, pop and halt.
- Next cycle: COUNT=0, PC={REDIRECT_PC[31:2],2'b00}, FSM=RUN.
- A same-cycle pop SHALL still be considered consumed.
REQ-024 A simultaneous push and pop SHALL leave COUNT unchanged and preserve FIFO order.
REQ-025 OUT_VALID SHALL be (COUNT != 0).
- OUT_PC and OUT_INST SHALL be driven from the head entry.
- They SHALL hold stable while OUT_VALID=1 and OUT_READY=0.
REQ-026 Latency: an entry pushed at edge N SHALL be presented with OUT_VALID=1 after edge N, i.e. 1 cycle fetch-to-decode.
REQ-027 IMEM_ADDR SHALL always equal PC; no other outputs are combinational from inputs.

Reset
REQ-028 On RST=1 the block SHALL asynchronously set:
- PC=RESET_PC, COUNT=0, FSM=RUN.
- OUT_VALID=0, HALTED=0, OUT_PC=0, OUT_INST=0, with all queue storage cleared.
REQ-029 RST asserted mid-operation SHALL discard all queued entries and any pending redirect.
REQ-030 The first push SHALL occur at the first rising CLK edge after RST deasserts.

Structure
REQ-031 The shared package cpu_pkg SHALL hold:
- XLEN=32 and the default HALT_WORD.
- The fetch FSM state encoding (RUN=0, HALT=1).
REQ-032 Queue storage and read/write pointers SHALL live in one sub-module, fetch_fifo, which has push, pop, flush and count.
- PC register, FSM and redirect logic SHALL stay in inst_fetch_queue.

Verification
REQ-033 Stream: OUT_READY=1, memory 0x00..0x0C = 0x00500093, 0x00A00113, 0x002081B3, 0x00000000.
- Required: three entries, PC 0,4,8 in order; HALTED=1 after fetching 0x0C; OUT_VALID=0 after drain.
REQ-034 Backpressure: OUT_READY=0 for 5 cycles from reset.
- Required: COUNT saturates at DEPTH; IMEM_ADDR stops at 4*DEPTH; OUT_PC=0 held stable.
- Then OUT_READY=1: PCs continue with no gap or duplicate.
REQ-035 Redirect: with the queue full at PC 8, assert REDIRECT with REDIRECT_PC=0x00000042.
- Required: next cycle COUNT=0, IMEM_ADDR=0x40.
- The following cycle: OUT_PC=0x40.
REQ-036 Redirect from HALT: after the REQ-033 halt, REDIRECT_PC=0x4.
- Required: HALTED=0 and OUT_PC=4 within 2 cycles.
REQ-037 Wrap: RESET_PC=32'hFFFFFFF8 with nonzero memory words.
- Required: OUT_PC sequence FFFFFFF8, FFFFFFFC, 00000000.
REQ-038 Async reset: assert RST between edges while COUNT=2.
- Required: OUT_VALID=0 and IMEM_ADDR=RESET_PC before the next edge.
